serial_arith_sequencer: RTL and testbench

- Multi-cycle, bit-serial front end that drives one instance of the 1-bit arithmetic_circuit slice, one bit per clock, LSB first.
- Turns the slice into a WIDTH-bit adder/subtractor/incrementer/decrementer with a registered carry chain.
- Sits directly upstream of the slice (feeds a_i/b_i/cin_i/sel_i) and collects its d_o/cout_o into a result register.
- Serves as the serial datapath option beside the future 32-bit parallel ALU.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/arithmetic_circuit.sv | 40 ++++
 rtl/serial_arith_sequencer.sv | 173 +++++++++++++++++
 tb/tb_serial_arith_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the serial arithmetic datapath.
//   - Operand-select encodings understood by the arithmetic_circuit bit slice.
//   - State encoding for the serial_arith_sequencer control FSM.
// No ports (package).
// ----------------------------------------------------------------------------
package alu_pkg;

    // Second-operand selection: A+B, A+~B, A+0, A+all-ones
    localparam logic [1:0] SEL_ADD  = 2'b00;
    localparam logic [1:0] SEL_ADDN = 2'b01;
    localparam logic [1:0] SEL_PASS = 2'b10;
    localparam logic [1:0] SEL_ONES = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/arithmetic_circuit.sv
// ----------------------------------------------------------------------------
// arithmetic_circuit
// One-bit arithmetic slice: full adder whose second operand is chosen by sel.
//   a_i    in  1  operand A bit
//   b_i    in  1  operand B bit
//   cin_i  in  1  carry in
//   sel_i  in  2  00 A+B, 01 A+~B, 10 A+0, 11 A+1
//   d_o    out 1  sum bit
//   cout_o out 1  carry out
// ----------------------------------------------------------------------------
module arithmetic_circuit
    import alu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [1:0] sel_i,
    output logic       d_o,
    output logic       cout_o
);

    logic y;

    // Pick the second adder operand for this bit from B according to sel.
    always_comb begin
        y = 1'b0;
        case (sel_i)
            SEL_ADD:  y = b_i;
            SEL_ADDN: y = ~b_i;
            SEL_PASS: y = 1'b0;
            SEL_ONES: y = 1'b1;
            default:  y = 1'b0;
        endcase
    end

    // Plain full adder on A and the selected operand.
    assign d_o    = a_i ^ y ^ cin_i;
    assign cout_o = (a_i & y) | (cin_i & (a_i ^ y));

endmodule

// File: rtl/serial_arith_sequencer.sv
// ----------------------------------------------------------------------------
// serial_arith_sequencer
// Bit-serial WIDTH-bit adder/subtractor/incrementer/decrementer built around a
// single arithmetic_circuit slice. Operands are processed LSB first, one bit
// per clock, with the carry held in a register between bits.
//
// Ports:
//   clk_i       in  1      clock, rising edge
//   rst_ni      in  1      asynchronous active-low reset
//   start_i     in  1      request, accepted in IDLE or DONE
//   a_i, b_i    in  WIDTH  operands, captured with start
//   sel_i       in  2      op select, captured with start
//   cin_i       in  1      initial carry, captured with start
//   busy_o      out 1      high while bits are being processed
//   done_o      out 1      one-cycle pulse, result valid
//   result_o    out WIDTH  result, held until the next completed op
//   cout_o      out 1      carry out of the MSB
//   overflow_o  out 1      signed overflow
//   zero_o      out 1      result == 0     (SERIAL_ALU_STATUS_FLAGS_EN only)
//   neg_o       out 1      result MSB      (SERIAL_ALU_STATUS_FLAGS_EN only)
//
// Optional macro: SERIAL_ALU_STATUS_FLAGS_EN adds the zero_o/neg_o flags.
// ----------------------------------------------------------------------------
module serial_arith_sequencer
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       sel_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             cout_o,
    output logic             overflow_o
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
    ,
    output logic             zero_o,
    output logic             neg_o
`endif
);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] result_q;
    logic [1:0]       sel_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             slice_d;
    logic             slice_cout;
    logic             cout_q;
    logic             ovf_q;

    arithmetic_circuit u_slice (
        .a_i    (a_sh[0]),
        .b_i    (b_sh[0]),
        .cin_i  (carry_q),
        .sel_i  (sel_q),
        .d_o    (slice_d),
        .cout_o (slice_cout)
    );

    // The counter stops at WIDTH-1 rather than wrapping, so the exit compare
    // works even when WIDTH is a power of two.
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // The lower WIDTH-1 result bits accumulate in res_sh; the final sum bit
    // is appended on the last edge so the whole word lands in one step.
    assign res_next = {slice_d, res_sh};

    // Control state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status decode. DONE accepts a new start just like IDLE
    // so operations can run back to back with one gap cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial datapath. On accept the operands are captured; during RUN the
    // operands shift right one bit per clock while the sum bits shift in from
    // the top. The visible result and flags only change on the final bit,
    // where carry_q is still the carry into the MSB.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            result_q <= '0;
            sel_q    <= '0;
            carry_q  <= 1'b0;
            cnt      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
            zero_o   <= 1'b0;
            neg_o    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh    <= a_i;
            b_sh    <= b_i;
            sel_q   <= sel_i;
            carry_q <= cin_i;
            cnt     <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
            res_sh  <= res_next[WIDTH-1:1];
            carry_q <= slice_cout;
            if (last_bit) begin
                result_q <= res_next;
                cout_q   <= slice_cout;
                ovf_q    <= carry_q ^ slice_cout;
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
                zero_o   <= (res_next == '0);
                neg_o    <= slice_d;
`endif
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign result_o   = result_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_arith_sequencer.sv
// ----------------------------------------------------------------------------
// tb_serial_arith_sequencer
// Self-checking bench for serial_arith_sequencer at WIDTH=8. Expected values
// come from an integer reference model of A + Y + cin. Define
// SERIAL_ALU_STATUS_FLAGS_EN to also exercise zero_o/neg_o.
// ----------------------------------------------------------------------------
module tb_serial_arith_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [1:0]   sel_i;
    logic         cin_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         cout_o;
    logic         overflow_o;
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
    logic         zero_o;
    logic         neg_o;
`endif

    int errors = 0;
    int checks = 0;

    serial_arith_sequencer #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .sel_i      (sel_i),
        .cin_i      (cin_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
        ,
        .zero_o     (zero_o),
        .neg_o      (neg_o)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: integer sum of A, the selected operand and carry; overflow
    // from the signed interpretation falling outside the 8-bit range.
    function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] sel, input logic cin);
        int y;
        int s;
        int sa;
        int sy;
        int ss;
        logic [7:0] r;
        logic co;
        logic ov;
        case (sel)
            2'd0:    y = int'(b);
            2'd1:    y = 255 - int'(b);
            2'd2:    y = 0;
            default: y = 255;
        endcase
        s  = int'(a) + y + int'(cin);
        co = (s > 255);
        r  = 8'(s % 256);
        sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
        sy = (y >= 128) ? y - 256 : y;
        ss = sa + sy + int'(cin);
        ov = (ss > 127) || (ss < -128);
        return {ov, co, r};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one operation for a single clock edge, then scramble the
    // operand inputs so any late sampling shows up as a wrong result.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [1:0] sel, input logic cin);
        @(negedge clk);
        a_i     = a;
        b_i     = b;
        sel_i   = sel;
        cin_i   = cin;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = 8'($urandom);
        b_i     = 8'($urandom);
        sel_i   = 2'($urandom);
        cin_i   = 1'($urandom);
    endtask

    // Step negedge by negedge until done_o, with a cycle budget.
    task automatic waitDone(output int busy_cycles, output logic seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic checkResult(input string tag, input logic [9:0] exp);
        checkOutput({tag, "_result"}, 64'(result_o), 64'(exp[7:0]));
        checkOutput({tag, "_cout"}, 64'(cout_o), 64'(exp[8]));
        checkOutput({tag, "_ovf"}, 64'(overflow_o), 64'(exp[9]));
`ifdef SERIAL_ALU_STATUS_FLAGS_EN
        checkOutput({tag, "_zero"}, 64'(zero_o), 64'(exp[7:0] == 8'd0));
        checkOutput({tag, "_neg"}, 64'(neg_o), 64'(exp[7]));
`endif
    endtask

    task automatic runOp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] sel, input logic cin);
        logic [9:0] exp;
        int         busy_cycles;
        logic       seen;
        exp = refModel(a, b, sel, cin);
        applyStimulus(a, b, sel, cin);
        waitDone(busy_cycles, seen);
        checkOutput({tag, "_done"}, 64'(seen), 64'd1);
        checkOutput({tag, "_busycyc"}, 64'(busy_cycles), 64'(W));
        checkResult(tag, exp);
        @(negedge clk);
        checkOutput({tag, "_donepulse"}, 64'(done_o), 64'd0);
        checkOutput({tag, "_idlebusy"}, 64'(busy_o), 64'd0);
        checkOutput({tag, "_held"}, 64'(result_o), 64'(exp[7:0]));
    endtask

    initial begin
        logic [9:0] exp1;
        logic [9:0] exp2;
        int         busy_cycles;
        int         gap;
        int         done_count;
        logic       seen;

        rst_n   = 1'b0;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        sel_i   = '0;
        cin_i   = 1'b0;

        @(negedge clk);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_result", 64'(result_o), 64'd0);
        checkOutput("rst_cout", 64'(cout_o), 64'd0);
        checkOutput("rst_ovf", 64'(overflow_o), 64'd0);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        runOp("add", 8'h35, 8'h0F, 2'b00, 1'b0);
        runOp("sub", 8'h10, 8'h01, 2'b01, 1'b1);
        runOp("addovf", 8'h7F, 8'h01, 2'b00, 1'b0);
        runOp("dec", 8'h00, 8'hA5, 2'b11, 1'b0);
        runOp("inc", 8'hFF, 8'h3C, 2'b10, 1'b1);
        runOp("xfer", 8'h96, 8'h00, 2'b11, 1'b1);
        runOp("subovf", 8'h80, 8'h01, 2'b01, 1'b1);

        $display("[TB] back-to-back with start held high");
        exp1 = refModel(8'h5C, 8'h27, 2'b00, 1'b0);
        exp2 = refModel(8'hE1, 8'h4D, 2'b01, 1'b1);
        @(negedge clk);
        a_i     = 8'h5C;
        b_i     = 8'h27;
        sel_i   = 2'b00;
        cin_i   = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        a_i   = 8'hE1;
        b_i   = 8'h4D;
        sel_i = 2'b01;
        cin_i = 1'b1;
        waitDone(busy_cycles, seen);
        checkOutput("b2b_done1", 64'(seen), 64'd1);
        checkResult("b2b_op1", exp1);
        gap = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            gap++;
            start_i = 1'b0;
            if (done_o) break;
        end
        checkOutput("b2b_gap", 64'(gap), 64'd9);
        checkResult("b2b_op2", exp2);

        $display("[TB] reset in the middle of an operation");
        runOp("prerst", 8'hC0, 8'hC1, 2'b00, 1'b0);
        applyStimulus(8'h5A, 8'h33, 2'b00, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_done", 64'(done_o), 64'd0);
        checkOutput("midrst_result", 64'(result_o), 64'd0);
        checkOutput("midrst_cout", 64'(cout_o), 64'd0);
        checkOutput("midrst_ovf", 64'(overflow_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done_o) done_count++;
        end
        checkOutput("midrst_nodone", 64'(done_count), 64'd0);
        runOp("postrst", 8'h5A, 8'h33, 2'b00, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            runOp($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom),
                  2'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
